// File: rtl/multiplexor_arbitrado_if.sv
// rtl/multiplexor_arbitrado_if.sv - producer/consumer bus of the arbitrated N-channel multiplexer
interface multiplexor_arbitrado_if #(
    parameter int N       = 32,
    parameter int CANALES = 4
);
    localparam int SW = (CANALES > 1) ? $clog2(CANALES) : 1;

    logic [CANALES*N-1:0] datoIn;
    logic [CANALES-1:0]   validIn;
    logic [CANALES-1:0]   readyIn;
    logic                 modo;
    logic [SW-1:0]        selDato;
    logic [N-1:0]         datoOutput;
    logic [SW-1:0]        selOut;
    logic                 validOut;
    logic                 readyOut;

    modport master (
        output datoIn, validIn, modo, selDato, readyOut,
        input  readyIn, datoOutput, selOut, validOut
    );

    modport slave (
        input  datoIn, validIn, modo, selDato, readyOut,
        output readyIn, datoOutput, selOut, validOut
    );
endinterface

// File: rtl/multiplexor_arbitrado.sv
// rtl/multiplexor_arbitrado.sv - registered N-channel mux with fixed-select or round-robin arbitration
module multiplexor_arbitrado #(
    parameter int N       = 32,
    parameter int CANALES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    multiplexor_arbitrado_if.slave bus
);
    localparam int SW = (CANALES > 1) ? $clog2(CANALES) : 1;

    logic [N-1:0]       r_dato;
    logic [SW-1:0]      r_sel;
    logic               r_valid;
    logic [SW-1:0]      r_ptr;

    logic               w_carga;
    logic               w_gnt_any;
    logic [SW-1:0]      w_gnt_idx;
    logic [CANALES-1:0] w_grant;
    logic               w_xfer;
    logic [N-1:0]       w_dato_sel;

    // Round-robin scans offsets from high to low so the lowest offset from r_ptr wins.
    always_comb begin
        logic [SW:0] v_idx;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        v_idx     = '0;
        if (!bus.modo) begin
            if (({1'b0, bus.selDato} < (SW+1)'(CANALES)) && bus.validIn[bus.selDato]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = bus.selDato;
            end
        end else begin
            for (int i = CANALES - 1; i >= 0; i--) begin
                v_idx = {1'b0, r_ptr} + (SW+1)'(i);
                if (v_idx >= (SW+1)'(CANALES)) begin
                    v_idx = v_idx - (SW+1)'(CANALES);
                end
                if (bus.validIn[v_idx[SW-1:0]]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = v_idx[SW-1:0];
                end
            end
        end
    end

    always_comb begin
        w_grant    = '0;
        w_dato_sel = '0;
        for (int k = 0; k < CANALES; k++) begin
            if (w_gnt_any && (w_gnt_idx == SW'(k))) begin
                w_grant[k] = 1'b1;
                w_dato_sel = bus.datoIn[k*N +: N];
            end
        end
    end

    assign w_carga     = !r_valid || bus.readyOut;
    assign w_xfer      = w_carga && w_gnt_any;
    assign bus.readyIn = w_carga ? w_grant : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dato  <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else if (w_carga) begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_dato <= w_dato_sel;
                r_sel  <= w_gnt_idx;
                // The pointer only follows round-robin transfers; fixed-mode traffic leaves it alone.
                if (bus.modo) begin
                    r_ptr <= (w_gnt_idx == SW'(CANALES - 1)) ? '0 : w_gnt_idx + 1'b1;
                end
            end
        end
    end

    assign bus.datoOutput = r_dato;
    assign bus.selOut     = r_sel;
    assign bus.validOut   = r_valid;
endmodule

// File: tb/tb_multiplexor_arbitrado.sv
// tb/tb_multiplexor_arbitrado.sv - directed and randomized bench for multiplexor_arbitrado
module tb_multiplexor_arbitrado;
    localparam int N  = 32;
    localparam int C  = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multiplexor_arbitrado_if #(.N(N), .CANALES(C)) bus ();
    multiplexor_arbitrado #(.N(N), .CANALES(C)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [N-1:0]  m_dato;
    logic [SW-1:0] m_sel;
    logic          m_valid;
    int            m_ptr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int grant_of();
        if (!bus.modo) begin
            if (int'(bus.selDato) < C && bus.validIn[bus.selDato]) return int'(bus.selDato);
            return -1;
        end
        for (int i = 0; i < C; i++) begin
            if (bus.validIn[(m_ptr + i) % C]) return (m_ptr + i) % C;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_dato  = '0;
        m_sel   = '0;
        m_valid = 1'b0;
        m_ptr   = 0;
    endtask

    task automatic tick();
        int             g;
        logic           carga;
        logic [C-1:0]   exp_rdy;
        logic [N-1:0]   n_dato;
        #3;
        g       = grant_of();
        carga   = !m_valid || bus.readyOut;
        exp_rdy = (carga && g >= 0) ? C'(1 << g) : '0;
        n_dato  = (g >= 0) ? bus.datoIn[g*N +: N] : '0;
        check("readyIn",    64'(bus.readyIn),    64'(exp_rdy));
        check("validOut",   64'(bus.validOut),   64'(m_valid));
        check("datoOutput", 64'(bus.datoOutput), 64'(m_dato));
        check("selOut",     64'(bus.selOut),     64'(m_sel));
        @(posedge clk);
        if (rst && carga) begin
            if (g >= 0) begin
                m_dato  = n_dato;
                m_sel   = SW'(g);
                m_valid = 1'b1;
                if (bus.modo) m_ptr = (g + 1) % C;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_dato",  64'(bus.datoOutput), 64'd0);
        check("rst_valid", 64'(bus.validOut),   64'd0);
        check("rst_sel",   64'(bus.selOut),     64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        for (int k = 0; k < C; k++) bus.datoIn[k*N +: N] = N'(k + 1);
        bus.validIn  = 4'b1111;
        bus.modo     = 1'b1;
        bus.selDato  = '0;
        bus.readyOut = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 1: asynchronous reset while a word is held, then first grant from channel 0
        repeat (3) tick();
        check("pre_rst_valid", 64'(bus.validOut), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_dato",  64'(bus.datoOutput), 64'd0);
        check("arst_valid", 64'(bus.validOut),   64'd0);
        check("arst_sel",   64'(bus.selOut),     64'd0);
        model_reset();
        @(posedge clk);
        #1;
        tick();
        rst = 1'b1;
        tick();
        check("t1_first_dato", 64'(bus.datoOutput), 64'd1);
        check("t1_first_sel",  64'(bus.selOut),     64'd0);

        // 2: fixed sweep
        bus.modo = 1'b0;
        for (int s = 0; s < C; s++) begin
            bus.selDato = SW'(s);
            tick();
            check("t2_dato", 64'(bus.datoOutput), 64'(s + 1));
            repeat (9) tick();
        end

        // 3: round-robin fairness, then sparse requests
        bus.modo = 1'b1;
        repeat (8) tick();
        bus.validIn = 4'b1010;
        repeat (6) tick();

        // 4: back-pressure
        bus.validIn = 4'b1111;
        do_reset();
        tick();
        check("t4_load", 64'(bus.datoOutput), 64'd1);
        bus.readyOut = 1'b0;
        repeat (5) tick();
        check("t4_hold_dato",  64'(bus.datoOutput), 64'd1);
        check("t4_hold_valid", 64'(bus.validOut),   64'd1);
        bus.readyOut = 1'b1;
        tick();
        check("t4_next", 64'(bus.datoOutput), 64'd2);

        // 5: idle and consume, fixed select on a non-requesting channel
        bus.validIn = 4'b0000;
        tick();
        check("t5_drain_valid", 64'(bus.validOut),   64'd0);
        check("t5_keep_dato",   64'(bus.datoOutput), 64'd2);
        bus.modo    = 1'b0;
        bus.selDato = 2'd2;
        bus.validIn = 4'b1000;
        repeat (3) tick();
        check("t5_no_xfer", 64'(bus.validOut), 64'd0);

        // 6: pointer retained across a mode switch
        do_reset();
        bus.modo    = 1'b1;
        bus.validIn = 4'b1111;
        repeat (2) tick();
        bus.modo    = 1'b0;
        bus.selDato = 2'd0;
        repeat (3) tick();
        check("t6_fixed", 64'(bus.datoOutput), 64'd1);
        bus.modo = 1'b1;
        tick();
        check("t6_rr_resume", 64'(bus.datoOutput), 64'd3);

        // randomized traffic against the reference model
        for (int r = 0; r < 400; r++) begin
            for (int k = 0; k < C; k++) bus.datoIn[k*N +: N] = $urandom;
            bus.validIn  = C'($urandom_range(0, 15));
            bus.modo     = 1'($urandom_range(0, 3) != 0);
            bus.selDato  = SW'($urandom_range(0, 3));
            bus.readyOut = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 60) == 0) do_reset();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multiplexor_arbitrado.md
# multiplexor_arbitrado

Registered N-channel multiplexer with valid/ready handshaking, the parametrised successor to the 4-input combinational multiplexor in the datapath. It selects one of `CANALES` producers, by an explicit select or by round-robin arbitration, and presents the winning word on a one-entry output register. It sits between multiple requesters (fetch, load/store, DMA-style sprite fetch) and a shared consumer such as the memory port or register-file write bus.

## Interface
- `N`, 32: data width in bits.
- `CANALES`, 4: number of input channels, at least 2. `SW = $clog2(CANALES)`.

Ports:
- `clk`  in  1  single clock; everything is sampled on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `datoIn`  in  CANALES*N  packed inputs; channel k occupies bits [k*N +: N].
- `validIn`  in  CANALES  per-channel request.
- `readyIn`  out  CANALES  per-channel accept, one-hot or zero.
- `modo`  in  1  0 = fixed select, 1 = round-robin.
- `selDato`  in  SW  channel index used when `modo`=0.
- `datoOutput`  out  N  registered selected word.
- `selOut`  out  SW  index of the channel held in `datoOutput`.
- `validOut`  out  1  output register holds a word.
- `readyOut`  in  1  consumer accepts the word.

## Operation
- **Output register load.** `carga = !validOut || readyOut`. The register loads only when `carga`=1 and a grant exists.
- **Fixed mode (`modo`=0).**
  - Grant goes to channel `selDato` if `validIn[selDato]`=1.
  - If `selDato` ≥ CANALES, there is no grant and the block holds idle.
- **Round-robin mode (`modo`=1).**
  - The search starts at pointer `ptr` and wraps modulo CANALES.
  - The first channel found with `validIn` set wins.
  - After a transfer from channel k, `ptr` becomes (k+1) mod CANALES.
  - `ptr` changes only on a transfer. It is retained across mode switches and is not updated in fixed mode.
- **Input handshake.**
  - `readyIn[k] = carga && grant[k]`, purely combinational from current inputs and state.
  - A transfer on channel k occurs when `validIn[k] && readyIn[k]`.
- **On transfer:** `datoOutput` ← channel k data, `selOut` ← k, `validOut` ← 1.
- **On output consumption without a new transfer:** `validOut` ← 0. `datoOutput` and `selOut` keep their last values.
- **Simultaneous consume and transfer:** the register reloads with the new word, `validOut` stays 1, and throughput is one word per cycle.
- **Stall (`validOut`=1, `readyOut`=0):** all `readyIn` are 0 and `datoOutput`, `selOut` and `ptr` are frozen.
- **Valid stability:** once `validIn[k]` is asserted it must stay asserted until accepted. The block does not depend on this.

## Timing
- **Reset values:** `datoOutput`=0, `selOut`=0, `validOut`=0, `ptr`=0. The output register and `ptr` clear immediately on `rst` falling, independent of `clk`.
- **During reset:** `readyIn` is driven by combinational logic. With `validOut`=0 it may be nonzero, but no state updates while `rst` is low.
- **Reset mid-operation:** a held output word is lost and the first arbitration after release starts at channel 0.
- **Latency:** a word accepted at edge t appears on `datoOutput` with `validOut`=1 after edge t. Input to output is 1 cycle.
- **Select/mode timing:** `modo` and `selDato` are sampled combinationally in the same cycle as the grant. A change takes effect on the next arbitration with no extra delay.
- **Fairness:** in round-robin with all channels valid and `readyOut`=1, grants go k, k+1, …, wrapping, one per cycle. Any requesting channel is served within CANALES transfers.

## Test plan
All scenarios use N=32, CANALES=4, with `datoIn` channels 0–3 = 1, 2, 3, 4.

1. **Reset.** Assert `rst`=0 mid-cycle while `validOut`=1. Required: `datoOutput`=0, `validOut`=0 and `selOut`=0 immediately. After release with all valid, round-robin, `readyOut`=1, the first output is 1 with `selOut`=0.
2. **Fixed sweep.** `modo`=0, all `validIn`=1, `readyOut`=1, `selDato` = 0, 1, 2, 3 for 10 cycles each. Required: `datoOutput` = 1, 2, 3, 4, each lagging its select by one cycle. Only `readyIn[selDato]` is high.
3. **Round-robin fairness.** `modo`=1, all valid, `readyOut`=1. Required: outputs 1, 2, 3, 4, 1, 2… on consecutive cycles. Then set `validIn`=4'b1010. Required: outputs alternate 2 and 4 from the current pointer.
4. **Back-pressure.** Round-robin, all valid. Load word 1, then hold `readyOut`=0 for 5 cycles. Required: `datoOutput`=1 and `validOut`=1 held, `readyIn`=0, `ptr` unchanged. After `readyOut` rises, the next word is 2.
5. **Idle and consume.** `validIn`=0 with `readyOut`=1 after one word. Required: `validOut` falls the next cycle and `datoOutput` keeps its last value. In fixed mode with only `validIn[3]`=1 and `selDato`=2, there is no transfer and `validOut` stays 0.
6. **Mode switch.** After a round-robin grant to channel 1 (`ptr`=2), switch to `modo`=0, `selDato`=0 for 3 transfers, then back to round-robin with all valid. Required: three outputs of 1, then the next output is 3 (`ptr` retained at 2).
